spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_sclk_div.sv | 24 ++
 rtl/spi_controller.sv | 149 ++++++++++++++
 tb/tb_spi_controller.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI constants, register map and controller state encoding.
package spi_pkg;

  localparam int SPI_FRAME_W  = 16;
  localparam int SPI_ADDR_W   = 7;
  localparam int SPI_DATA_W   = 8;
  localparam int SPI_MAX_ADDR = 4;

  localparam logic [SPI_ADDR_W-1:0] EN_OUT_7_0  = 7'd0;
  localparam logic [SPI_ADDR_W-1:0] EN_OUT_15_8 = 7'd1;
  localparam logic [SPI_ADDR_W-1:0] PWM_CTRL    = 7'd2;
  localparam logic [SPI_ADDR_W-1:0] PWM_PERIOD  = 7'd3;
  localparam logic [SPI_ADDR_W-1:0] PWM_DUTY    = 7'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_GAP
  } spi_state_e;

  function automatic logic addr_ok(input logic [SPI_ADDR_W-1:0] addr);
    return addr <= SPI_ADDR_W'(SPI_MAX_ADDR);
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period timer: tick marks the last clk cycle of every CLK_DIV-cycle phase.
module spi_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = en && (cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// Write-only SPI master sending 16-bit {rw, addr, data} frames, mode 0, MSB first.
// Optional build macro SPI_CTRL_ADDR_CHECK_EN rejects addresses above SPI_MAX_ADDR.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_HALVES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [SPI_ADDR_W-1:0] req_addr,
  input  logic [SPI_DATA_W-1:0] req_data,
  input  logic                  abort,
  output logic                  nCS_out,
  output logic                  SCLK_out,
  output logic                  COPI_out,
  output logic                  done,
  output logic                  aborted,
  output logic                  busy,
  output spi_state_e            dbg_state
);

  spi_state_e              state, state_d;
  logic [SPI_FRAME_W-1:0]  frame_q, frame_d;
  logic [4:0]              edge_cnt, edge_d;
  logic [3:0]              gap_cnt, gap_d;
  logic [3:0]              nxt_idx;
  logic                    ncs_d, sclk_d, copi_d, done_d, aborted_d;
  logic                    tick, accept, addr_bad, abort_take;

  // Handshake: a frame is taken on any rising edge where req_valid && req_ready;
  // req_ready depends only on state (and rst), never on req_valid.
`ifdef SPI_CTRL_ADDR_CHECK_EN
  assign req_ready = (state == ST_IDLE) && !rst && !aborted;
  assign addr_bad  = !addr_ok(req_addr);
`else
  assign req_ready = (state == ST_IDLE) && !rst;
  assign addr_bad  = 1'b0;
`endif

  assign accept     = req_valid && req_ready;
  assign busy       = (state != ST_IDLE);
  assign abort_take = abort && (state inside {ST_SETUP, ST_SHIFT_HI, ST_SHIFT_LO});
  assign nxt_idx    = 4'd14 - edge_cnt[3:0];
  assign dbg_state  = state;

  spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .rst   (rst),
    .en    (busy),
    .clear ((state == ST_IDLE) || abort_take),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state;
    frame_d   = frame_q;
    edge_d    = edge_cnt;
    gap_d     = gap_cnt;
    ncs_d     = nCS_out;
    sclk_d    = SCLK_out;
    copi_d    = COPI_out;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    if (abort_take) begin
      // Abort wins even on the final hold cycle, so done never follows it.
      state_d   = ST_GAP;
      ncs_d     = 1'b1;
      sclk_d    = 1'b0;
      copi_d    = 1'b0;
      aborted_d = 1'b1;
      gap_d     = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept && addr_bad) begin
            aborted_d = 1'b1;
          end else if (accept) begin
            state_d = ST_SETUP;
            frame_d = {req_rw, req_addr, req_data};
            edge_d  = '0;
            ncs_d   = 1'b0;
            sclk_d  = 1'b0;
            copi_d  = req_rw;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            state_d = ST_SHIFT_HI;
            sclk_d  = 1'b1;
          end
        end
        ST_SHIFT_HI: begin
          if (tick) begin
            state_d = ST_SHIFT_LO;
            sclk_d  = 1'b0;
            edge_d  = edge_cnt + 5'd1;
            if (edge_cnt != 5'd15) copi_d = frame_q[nxt_idx];
          end
        end
        ST_SHIFT_LO: begin
          if (tick && edge_cnt == 5'd16) begin
            state_d = ST_GAP;
            ncs_d   = 1'b1;
            copi_d  = 1'b0;
            done_d  = 1'b1;
            gap_d   = '0;
          end else if (tick) begin
            state_d = ST_SHIFT_HI;
            sclk_d  = 1'b1;
          end
        end
        ST_GAP: begin
          if (tick && gap_cnt == 4'(GAP_HALVES - 1)) state_d = ST_IDLE;
          else if (tick) gap_d = gap_cnt + 4'd1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      frame_q  <= '0;
      edge_cnt <= '0;
      gap_cnt  <= '0;
      nCS_out  <= 1'b1;
      SCLK_out <= 1'b0;
      COPI_out <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      state    <= state_d;
      frame_q  <= frame_d;
      edge_cnt <= edge_d;
      gap_cnt  <= gap_d;
      nCS_out  <= ncs_d;
      SCLK_out <= sclk_d;
      COPI_out <= copi_d;
      done     <= done_d;
      aborted  <= aborted_d;
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: frame scoreboard plus a simple register-file peripheral per instance.
`timescale 1ns/1ps
module tb_spi_controller;
  import spi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_rw = 1'b0, abort = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       req_ready, ncs, sclk, copi, done, aborted, busy;
  spi_state_e st;

  logic       b_valid = 1'b0, b_rw = 1'b0, b_abort = 1'b0;
  logic [6:0] b_addr = '0;
  logic [7:0] b_data = '0;
  logic       b_ready, b_ncs, b_sclk, b_copi, b_done, b_aborted, b_busy;
  spi_state_e b_st;

  spi_controller dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_data(req_data), .abort(abort), .nCS_out(ncs), .SCLK_out(sclk),
    .COPI_out(copi), .done(done), .aborted(aborted), .busy(busy), .dbg_state(st)
  );

  spi_controller #(.CLK_DIV(2), .GAP_HALVES(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_rw(b_rw),
    .req_addr(b_addr), .req_data(b_data), .abort(b_abort), .nCS_out(b_ncs), .SCLK_out(b_sclk),
    .COPI_out(b_copi), .done(b_done), .aborted(b_aborted), .busy(b_busy), .dbg_state(b_st)
  );

  // ---------------- peripherals (write on nCS rise after 16 bits) ----------------
  logic [7:0]  regs1 [5];
  logic [15:0] p1_sh;
  int          p1_n;
  logic        p1_sclk, p1_ncs;
  always @(posedge clk) begin
    if (rst) begin
      p1_n <= 0; p1_sclk <= 1'b0; p1_ncs <= 1'b1; p1_sh <= '0;
      for (int i = 0; i < 5; i++) regs1[i] <= 8'h00;
    end else begin
      p1_sclk <= sclk;
      p1_ncs  <= ncs;
      if (!ncs && sclk && !p1_sclk) begin
        p1_sh <= {p1_sh[14:0], copi};
        p1_n  <= p1_n + 1;
      end
      if (ncs && !p1_ncs) begin
        if (p1_n == 16 && p1_sh[15] && p1_sh[14:8] <= 7'd4) regs1[p1_sh[10:8]] <= p1_sh[7:0];
        p1_n <= 0;
      end
    end
  end

  logic [7:0]  regs2 [5];
  logic [15:0] p2_sh;
  int          p2_n;
  logic        p2_sclk, p2_ncs;
  always @(posedge clk) begin
    if (rst) begin
      p2_n <= 0; p2_sclk <= 1'b0; p2_ncs <= 1'b1; p2_sh <= '0;
      for (int i = 0; i < 5; i++) regs2[i] <= 8'h00;
    end else begin
      p2_sclk <= b_sclk;
      p2_ncs  <= b_ncs;
      if (!b_ncs && b_sclk && !p2_sclk) begin
        p2_sh <= {p2_sh[14:0], b_copi};
        p2_n  <= p2_n + 1;
      end
      if (b_ncs && !p2_ncs) begin
        if (p2_n == 16 && p2_sh[15] && p2_sh[14:8] <= 7'd4) regs2[p2_sh[10:8]] <= p2_sh[7:0];
        p2_n <= 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not seen within budget", name);
  endtask

  // {done, aborted, sclk edges, nCS-low cycles, captured bits}
  function automatic logic [33:0] mk(input bit d, input bit a, input int e, input int low,
                                     input logic [15:0] b);
    return {d, a, 6'(e), 10'(low), b};
  endfunction

  logic        m_psclk = 1'b0, m_pncs = 1'b1;
  int          m_edges = 0, m_low = 0, sclk_rises = 0, ncs_rise_cyc = -1;
  logic [15:0] m_bits = '0;
  logic [33:0] obs;
  always @(negedge clk) begin
    if (rst) begin
      m_edges = 0; m_low = 0; m_bits = '0;
    end else begin
      if (!ncs) m_low++;
      if (sclk && !m_psclk) sclk_rises++;
      if (!ncs && sclk && !m_psclk) begin
        m_edges++;
        m_bits = {m_bits[14:0], copi};
      end
      if (ncs && !m_pncs) ncs_rise_cyc = cyc;
      if (done || aborted) begin
        obs = {done, aborted, 6'(m_edges), 10'(m_low), m_bits};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got %h expected no pulse", obs);
        end else begin
          check("frame", obs, exp_q.pop_front());
        end
        m_edges = 0; m_low = 0; m_bits = '0;
      end
    end
    m_psclk = sclk;
    m_pncs  = ncs;
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic issue(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                       input bit keep, output int acc);
    bit got = 0;
    req_rw = rw; req_addr = addr; req_data = data; req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 400 && !got; i++) begin
      #1;
      if (req_ready) begin
        got = 1;
        acc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      fail("accept");
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      if (!keep) req_valid = 1'b0;
    end
  endtask

  task automatic wait_rises(input int n, input string name);
    int   seen = 0;
    logic p = sclk;
    for (int i = 0; i < 2000 && seen < n; i++) begin
      @(negedge clk);
      if (sclk && !p) seen++;
      p = sclk;
    end
    if (seen < n) fail(name);
  endtask

  task automatic wait_idle(input string name);
    bit got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1;
    end
    if (!got) fail(name);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] exp2 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    int acc, acc2, r0;
    bit got;

    repeat (3) @(negedge clk);
    check("rst_ncs", ncs, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_copi", copi, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_aborted", aborted, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", req_ready, 1'b0);
    check("rst_state", 34'(st), 34'(ST_IDLE));
    rst = 1'b0;
    #1 check("ready_after_rst", req_ready, 1'b1);
    @(negedge clk);

    // write addr 4 data 0x80
    exp_q.push_back(mk(1, 0, 16, 132, 16'h8480));
    issue(1'b1, 7'd4, 8'h80, 1'b0, acc);
    wait_idle("idle_t1");
    check("periph_reg4", regs1[4], 8'h80);

    // back-to-back with req_valid held high
    r0 = sclk_rises;
    exp_q.push_back(mk(1, 0, 16, 132, 16'h013C));
    exp_q.push_back(mk(1, 0, 16, 132, 16'h83C3));
    issue(1'b0, 7'd1, 8'h3C, 1'b1, acc);
    issue(1'b1, 7'd3, 8'hC3, 1'b0, acc2);
    check("b2b_accept_gap", 34'(acc2 - ncs_rise_cyc), 34'd8);
    wait_idle("idle_b2b");
    check("b2b_sclk_edges", 34'(sclk_rises - r0), 34'd32);
    check("periph_reg3", regs1[3], 8'hC3);

    // abort after the 5th rising edge
    exp_q.push_back(mk(0, 1, 5, 37, 16'h0010));
    issue(1'b1, 7'd2, 8'hA5, 1'b0, acc);
    wait_rises(5, "rises_abort");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ncs", ncs, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_pulse", aborted, 1'b1);
    check("abort_no_done", done, 1'b0);
    wait_idle("idle_abort");
    check("abort_reg2_kept", regs1[2], 8'h00);

    // abort in IDLE is ignored
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", busy, 1'b0);
    check("idle_abort_pulse", aborted, 1'b0);

    // abort on the final hold cycle beats done
    exp_q.push_back(mk(0, 1, 16, 132, 16'h005A));
    issue(1'b0, 7'd0, 8'h5A, 1'b0, acc);
    wait_rises(16, "rises_last");
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("last_lo_no_done", done, 1'b0);
    check("last_lo_aborted", aborted, 1'b1);
    wait_idle("idle_last");

    // abort in GAP is ignored and GAP keeps its length
    exp_q.push_back(mk(1, 0, 16, 132, 16'h8133));
    issue(1'b1, 7'd1, 8'h33, 1'b0, acc);
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (ncs) got = 1;
    end
    if (!got) fail("ncs_rise_gap");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("gap_abort_ignored", aborted, 1'b0);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      if (req_ready) got = 1;
      else @(negedge clk);
    end
    if (!got) fail("gap_end");
    check("gap_len", 34'(cyc - ncs_rise_cyc), 34'd8);
    check("periph_reg1", regs1[1], 8'h33);
    @(negedge clk);

    // reset at the 10th rising edge
    issue(1'b1, 7'd4, 8'h7E, 1'b0, acc);
    wait_rises(10, "rises_rst");
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ncs", ncs, 1'b1);
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    #1 check("midrst_ready", req_ready, 1'b1);
    r0 = sclk_rises;
    repeat (60) @(negedge clk);
    check("midrst_no_edges", 34'(sclk_rises - r0), 34'd0);

    // address range check
    r0 = sclk_rises;
`ifdef SPI_CTRL_ADDR_CHECK_EN
    exp_q.push_back(mk(0, 1, 0, 0, 16'h0000));
    issue(1'b1, 7'd5, 8'h99, 1'b0, acc);
    check("badaddr_aborted", aborted, 1'b1);
    check("badaddr_ncs", ncs, 1'b1);
    check("badaddr_ready_low", req_ready, 1'b0);
    @(negedge clk);
    check("badaddr_ready_back", req_ready, 1'b1);
    check("badaddr_edges", 34'(sclk_rises - r0), 34'd0);
`else
    exp_q.push_back(mk(1, 0, 16, 132, 16'h8599));
    issue(1'b1, 7'd5, 8'h99, 1'b0, acc);
    wait_idle("idle_addr5");
    check("addr5_edges", 34'(sclk_rises - r0), 34'd16);
`endif

    // CLK_DIV=2 instance writing the full register map
    for (int k = 0; k < 5; k++) begin
      b_rw = 1'b1; b_addr = 7'(k); b_data = exp2[k]; b_valid = 1'b1;
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
        #1;
        if (b_ready) got = 1;
        else @(negedge clk);
      end
      if (!got) fail("b_accept");
      @(posedge clk);
      @(negedge clk);
      b_valid = 1'b0;
      got = 0;
      for (int i = 0; i < 400 && !got; i++) begin
        @(negedge clk);
        if (!b_busy) got = 1;
      end
      if (!got) fail("b_idle");
    end
    for (int k = 0; k < 5; k++) check("div2_reg", regs2[k], exp2[k]);

    repeat (5) @(negedge clk);
    check("queue_empty", 34'(exp_q.size()), 34'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
